// File: rtl/sar_conv_sequencer.sv
// SAR ADC conversion sequencer: sample phase, NUM_BITS-step binary search, single-entry result register.
// Optional overrun detection is compiled in with `define SAR_SEQ_OVERRUN_EN; otherwise overrun is tied low.
//   state   | meaning
//   IDLE    | waiting for sample_sig
//   SAMPLE  | track phase, sample_hold high
//   CONVERT | binary search, dac_code = sar
module sar_conv_sequencer #(
    parameter int NUM_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_sig,
    input  logic                cmp_out,
    output logic                sample_hold,
    output logic [NUM_BITS-1:0] dac_code,
    output logic                busy,
    output logic [NUM_BITS-1:0] data_out,
    output logic                data_valid,
    input  logic                data_ready,
    output logic                overrun,
    input  logic                ovr_clr
);
    localparam int IDX_W = (NUM_BITS > 2) ? $clog2(NUM_BITS) : 1;

    typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT} state_t;

    state_t              state;
    logic [IDX_W-1:0]    idx;
    logic [NUM_BITS-1:0] sar;
    logic [NUM_BITS-1:0] trial;
    logic                load;
    logic                handshake;

    // sar is held at zero outside CONVERT so it can drive the DAC directly
    assign dac_code    = sar;
    assign sample_hold = (state == SAMPLE);
    assign busy        = (state != IDLE);
    assign load        = (state == CONVERT) && (idx == '0);
    assign handshake   = data_valid && data_ready;

    always_comb begin
        trial = sar;
        if (!cmp_out)
            trial[idx] = 1'b0;
        if (idx != '0)
            trial[idx - IDX_W'(1)] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            sar        <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sample_sig)
                        state <= SAMPLE;
                end
                SAMPLE: begin
                    state <= CONVERT;
                    sar   <= {1'b1, {(NUM_BITS-1){1'b0}}};
                    idx   <= IDX_W'(NUM_BITS-1);
                end
                CONVERT: begin
                    if (idx != '0) begin
                        sar <= trial;
                        idx <= idx - IDX_W'(1);
                    end else begin
                        // final bit: a start here chains straight into the next sample phase
                        sar        <= '0;
                        data_out   <= trial;
                        data_valid <= 1'b1;
                        state      <= sample_sig ? SAMPLE : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (handshake && !load)
                data_valid <= 1'b0;
        end
    end

`ifdef SAR_SEQ_OVERRUN_EN
    logic missed;
    logic clobber;

    assign missed  = sample_sig && ((state == SAMPLE) || ((state == CONVERT) && (idx != '0)));
    assign clobber = load && data_valid && !data_ready;

    always_ff @(posedge clk) begin
        if (rst)
            overrun <= 1'b0;
        else if (missed || clobber)
            overrun <= 1'b1;
        else if (ovr_clr)
            overrun <= 1'b0;
    end
`else
    logic unused_ovr_clr;

    assign unused_ovr_clr = ovr_clr;
    assign overrun        = 1'b0;
`endif

endmodule

// File: tb/tb_sar_conv_sequencer.sv
// Directed self-checking bench for sar_conv_sequencer (NUM_BITS=4) with an ideal comparator model.
// Overrun expectations follow whether SAR_SEQ_OVERRUN_EN is defined for the build.
module tb_sar_conv_sequencer;
`ifdef SAR_SEQ_OVERRUN_EN
    localparam logic OVR_EN = 1'b1;
`else
    localparam logic OVR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sample_sig = 1'b0;
    logic       cmp_out;
    logic       sample_hold;
    logic [3:0] dac_code;
    logic       busy;
    logic [3:0] data_out;
    logic       data_valid;
    logic       data_ready = 1'b0;
    logic       overrun;
    logic       ovr_clr = 1'b0;
    logic [3:0] vin = 4'd0;

    int checks = 0;
    int errors = 0;

    sar_conv_sequencer #(.NUM_BITS(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .sample_sig (sample_sig),
        .cmp_out    (cmp_out),
        .sample_hold(sample_hold),
        .dac_code   (dac_code),
        .busy       (busy),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .overrun    (overrun),
        .ovr_clr    (ovr_clr)
    );

    assign cmp_out = (vin >= dac_code);

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic consume();
        data_ready = 1'b1;
        step();
        data_ready = 1'b0;
        check("valid_after_consume", data_valid, 0);
    endtask

    // trials packs the four expected dac codes, first trial in the top nibble
    task automatic run_conv(input logic [3:0] v, input logic [15:0] trials, input logic [3:0] result);
        vin = v;
        sample_sig = 1'b1;
        step();
        sample_sig = 1'b0;
        check("sample_dac", dac_code, 0);
        check("sample_hold", sample_hold, 1);
        check("sample_busy", busy, 1);
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("trial%0d_v%0d", i, v), dac_code, trials[15-4*i -: 4]);
        end
        step();
        check("result_data", data_out, result);
        check("result_valid", data_valid, 1);
        check("result_busy", busy, 0);
        consume();
    endtask

    // leaves the bench in the last CONVERT cycle of the conversion it started
    task automatic start_to_last(input logic [3:0] v);
        vin = v;
        sample_sig = 1'b1;
        step();
        sample_sig = 1'b0;
        repeat (4) step();
    endtask

    task automatic clear_ovr();
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
    endtask

    initial begin
        logic [3:0] b2b_vin [3];
        b2b_vin = '{4'd3, 4'd9, 4'd14};

        repeat (2) step();
        check("rst_sample_hold", sample_hold, 0);
        check("rst_dac", dac_code, 0);
        check("rst_busy", busy, 0);
        check("rst_data", data_out, 0);
        check("rst_valid", data_valid, 0);
        check("rst_overrun", overrun, 0);
        rst = 1'b0;
        step();

        run_conv(4'd11, 16'h8CAB, 4'd11);
        run_conv(4'd15, 16'h8CEF, 4'd15);
        run_conv(4'd0,  16'h8421, 4'd0);

        // back-to-back at the minimum period
        data_ready = 1'b1;
        vin = b2b_vin[0];
        sample_sig = 1'b1;
        step();
        sample_sig = 1'b0;
        for (int k = 0; k < 3; k++) begin
            repeat (3) step();
            check("b2b_busy_mid", busy, 1);
            step();
            if (k < 2) sample_sig = 1'b1;
            step();
            sample_sig = 1'b0;
            if (k < 2) vin = b2b_vin[k+1];
            check($sformatf("b2b_data%0d", k), data_out, b2b_vin[k]);
            check("b2b_valid", data_valid, 1);
            check("b2b_busy_end", busy, (k < 2) ? 1 : 0);
            check("b2b_overrun", overrun, 0);
        end
        data_ready = 1'b0;
        step();

        // missed start two cycles into a conversion
        vin = 4'd7;
        sample_sig = 1'b1;
        step();
        sample_sig = 1'b0;
        step();
        sample_sig = 1'b1;
        step();
        sample_sig = 1'b0;
        check("miss_overrun", overrun, OVR_EN);
        check("miss_dac", dac_code, 4);
        repeat (3) step();
        check("miss_data", data_out, 7);
        check("miss_valid", data_valid, 1);
        check("miss_busy", busy, 0);
        clear_ovr();
        check("miss_ovr_clr", overrun, 0);
        consume();

        // backpressure across two conversions
        start_to_last(4'd5);
        step();
        check("bp_first", data_out, 5);
        check("bp_first_ovr", overrun, 0);
        start_to_last(4'd6);
        step();
        check("bp_data", data_out, 6);
        check("bp_valid", data_valid, 1);
        check("bp_overrun", overrun, OVR_EN);
        consume();
        clear_ovr();
        check("bp_ovr_clr", overrun, 0);

        // handshake coinciding with the second load
        start_to_last(4'd5);
        step();
        start_to_last(4'd6);
        data_ready = 1'b1;
        step();
        data_ready = 1'b0;
        check("hs_data", data_out, 6);
        check("hs_valid", data_valid, 1);
        check("hs_overrun", overrun, 0);

        // reset mid-conversion with an unconsumed result pending
        vin = 4'd9;
        sample_sig = 1'b1;
        step();
        sample_sig = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_dac", dac_code, 0);
        check("mid_rst_valid", data_valid, 0);
        check("mid_rst_data", data_out, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_hold", sample_hold, 0);
        step();
        check("post_rst_idle", busy, 0);
        run_conv(4'd13, 16'h8CED, 4'd13);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
